// File: rtl/hold_decoder_if.sv
// hold_decoder_if: select handshake and decoded-output bundle for hold_decoder.
interface hold_decoder_if #(parameter int SEL_W = 3);
  localparam int OUT_W = 1 << SEL_W;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             scan_start;
  logic [OUT_W-1:0] out;
  logic             busy;
  logic             done;
  modport master(output in_valid, sel, scan_start, input in_ready, out, busy, done);
  modport slave(input in_valid, sel, scan_start, output in_ready, out, busy, done);
endinterface

// File: rtl/hold_decoder.sv
// hold_decoder: registered one-hot decoder holding each output HOLD_CYCLES cycles.
// Define HOLD_DECODER_SCAN_EN to add the scan_start walk through every output.
module hold_decoder #(
  parameter int SEL_W       = 3,
  parameter int HOLD_CYCLES = 4
) (
  input logic          clk,
  input logic          rst_n,
  hold_decoder_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;
  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             last, ready, accept, scan_go;
`ifdef HOLD_DECODER_SCAN_EN
  logic [SEL_W-1:0] idx_q, idx_d;
  assign scan_go = (state_q == IDLE) && bus.scan_start;
`else
  logic unused_scan;
  assign unused_scan = bus.scan_start;
  assign scan_go     = 1'b0;
`endif
  assign last   = (cnt_q == '0);
  assign ready  = ((state_q == IDLE) && !scan_go) || ((state_q == HOLD) && last);
  assign accept = bus.in_valid && ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
`ifdef HOLD_DECODER_SCAN_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (scan_go) begin
          state_d = SCAN;
          cnt_d   = RELOAD;
          out_d   = OUT_W'(1);
`ifdef HOLD_DECODER_SCAN_EN
          idx_d   = '0;
`endif
        end else if (accept) begin
          state_d = HOLD;
          cnt_d   = RELOAD;
          out_d   = OUT_W'(1) << bus.sel;
        end
      end
      HOLD: begin
        if (!last) cnt_d = cnt_q - 1'b1;
        else begin
          done_d  = 1'b1;
          cnt_d   = accept ? RELOAD : cnt_q;
          out_d   = accept ? OUT_W'(1) << bus.sel : '0;
          state_d = accept ? HOLD : IDLE;
        end
      end
`ifdef HOLD_DECODER_SCAN_EN
      SCAN: begin
        if (!last) cnt_d = cnt_q - 1'b1;
        else if (idx_q == '1) begin
          done_d  = 1'b1;
          out_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
          cnt_d = RELOAD;
          out_d = out_q << 1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end
`ifdef HOLD_DECODER_SCAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end
`endif
  assign bus.in_ready = ready;
  assign bus.out      = out_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_hold_decoder.sv
// tb_hold_decoder: vector table, corner sequences and random model check of hold_decoder.
module tb_hold_decoder;
  localparam int HC = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  always #5 clk = ~clk;
  hold_decoder_if #(.SEL_W(3)) a ();
  hold_decoder_if #(.SEL_W(2)) b ();
  hold_decoder #(.SEL_W(3), .HOLD_CYCLES(HC)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  hold_decoder #(.SEL_W(2), .HOLD_CYCLES(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
  typedef struct {
    logic       v;
    logic [2:0] sel;
    logic [7:0] out;
    logic       done;
    logic       busy;
    logic       ready;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic v, logic [2:0] s, logic [7:0] o, logic d, logic bu, logic r);
    vec_t t;
    t.v = v; t.sel = s; t.out = o; t.done = d; t.busy = bu; t.ready = r;
    return t;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  int      m_code, m_left;
  bit      m_done, v;
  bit [2:0] s;
  initial begin
    a.in_valid = 1'b1; a.sel = 3'd5; a.scan_start = 1'b0;
    b.in_valid = 1'b0; b.sel = 2'd0; b.scan_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", a.out, 0);
    chk("rst_done", a.done, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_ready", a.in_ready, 1);
    // each row: inputs before an edge, outputs seen after it
    tbl.push_back(mk(1, 5, 8'h20, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h20, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h20, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h20, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(1, 2, 8'h04, 0, 1, 0));
    tbl.push_back(mk(1, 7, 8'h04, 0, 1, 0));
    tbl.push_back(mk(1, 7, 8'h04, 0, 1, 0));
    tbl.push_back(mk(1, 7, 8'h04, 0, 1, 1));
    tbl.push_back(mk(1, 7, 8'h80, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h80, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h80, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h80, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(1, 1, 8'h01, 0, 1, 0));
    tbl.push_back(mk(1, 2, 8'h01, 0, 1, 0));
    tbl.push_back(mk(1, 3, 8'h01, 0, 1, 1));
    tbl.push_back(mk(0, 4, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 5, 8'h00, 0, 0, 1));
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      a.in_valid = tbl[i].v;
      a.sel      = tbl[i].sel;
      @(negedge clk);
      chk($sformatf("tbl%0d_out", i), a.out, tbl[i].out);
      chk($sformatf("tbl%0d_done", i), a.done, tbl[i].done);
      chk($sformatf("tbl%0d_busy", i), a.busy, tbl[i].busy);
      chk($sformatf("tbl%0d_ready", i), a.in_ready, tbl[i].ready);
    end
    a.in_valid = 1'b1; a.sel = 3'd3;
    @(negedge clk);
    a.in_valid = 1'b0;
    chk("mid_out1", a.out, 8'h08);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", a.out, 0);
    chk("mid_rst_busy", a.busy, 0);
    chk("mid_rst_ready", a.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_no_done", a.done, 0);
      chk("mid_idle_out", a.out, 0);
      chk("mid_idle_busy", a.busy, 0);
    end
    b.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b.sel = 2'(i);
      chk("b_ready_pre", b.in_ready, 1);
      @(negedge clk);
      chk("b_out", b.out, 32'(1) << i);
      chk("b_ready", b.in_ready, 1);
      chk("b_done", b.done, i > 0);
    end
    b.in_valid = 1'b0;
    @(negedge clk);
    chk("b_end_out", b.out, 0);
    chk("b_end_done", b.done, 1);
    chk("b_end_busy", b.busy, 0);
`ifdef HOLD_DECODER_SCAN_EN
    a.scan_start = 1'b1; a.in_valid = 1'b1; a.sel = 3'd1;
    #1 chk("scan_ready_pre", a.in_ready, 0);
    @(negedge clk);
    a.scan_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("scan_out", a.out, 32'(1) << (i / HC));
      chk("scan_ready", a.in_ready, 0);
      chk("scan_busy", a.busy, 1);
      chk("scan_done", a.done, 0);
      if (i == 31) a.in_valid = 1'b0;
      @(negedge clk);
    end
    chk("scan_end_out", a.out, 0);
    chk("scan_end_done", a.done, 1);
    chk("scan_end_ready", a.in_ready, 1);
`else
    a.scan_start = 1'b1; a.in_valid = 1'b1; a.sel = 3'd6;
    #1 chk("noscan_ready", a.in_ready, 1);
    @(negedge clk);
    a.scan_start = 1'b0; a.in_valid = 1'b0;
    chk("noscan_out", a.out, 8'h40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("noscan_hold", a.out, 8'h40);
    end
    @(negedge clk);
    chk("noscan_end_out", a.out, 0);
    chk("noscan_end_done", a.done, 1);
`endif
    @(negedge clk);
    // reference: m_left = cycles the current line still has to stay high
    m_code = -1; m_left = 0; m_done = 0;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 2) != 0);
      s = 3'($urandom_range(0, 7));
      a.in_valid = v; a.sel = s;
      chk("rnd_ready", a.in_ready, m_left <= 1);
      @(posedge clk);
      m_done = (m_left == 1);
      if (v && m_left <= 1) begin
        m_code = s;
        m_left = HC;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_code = -1;
      end
      @(negedge clk);
      chk("rnd_out", a.out, m_code < 0 ? 0 : 32'(1) << m_code);
      chk("rnd_done", a.done, m_done);
      chk("rnd_busy", a.busy, m_left > 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
